tag_lookup_unit: RTL and testbench
==================================

// Module: tag_lookup_unit
//
// PURPOSE
//   N-way set-associative tag store with a pipelined lookup comparator for the L2 model.
//   Holds a tag and a valid bit for each (set, way). Compares a request tag against all
//   ways of the indexed set in parallel and returns hit, the hit way and a per-way hit vector.
//   Sits between the address decoder and the L2 data/replacement logic.
//   The fill/invalidate port is driven by the miss handler.
//
// PARAMETERS
//   tagBits    12  width of the tag field
//   indexBits   6  set index width; sets = 2**indexBits
//   ways        4  associativity; power of two, >= 2; wayBits = $clog2(ways)
//
// PORTS
//   clock            in   1          single clock; all state updates on rising edge
//   reset            in   1          synchronous, active-high
//   reqValid         in   1          lookup request valid
//   reqReady         out  1          unit accepts lookups (0 while clearing)
//   reqIndex         in   indexBits  set to look up
//   reqTag           in   tagBits    tag to compare
//   rspValid         out  1          lookup result valid (one-cycle pulse per request)
//   rspHit           out  1          any way of the set is valid and tag-equal
//   rspWay           out  wayBits    lowest-numbered hitting way; 0 on miss
//   rspHitVector     out  ways       bit w = way w valid and tag-equal
//   rspMultiHit      out  1          more than one bit of rspHitVector set (error flag)
//   fillValid        in   1          write (fillIndex, fillWay) this cycle
//   fillInvalidate   in   1          with fillValid: 1 = clear valid, 0 = write fillTag and set valid
//   fillIndex        in   indexBits  set to write
//   fillWay          in   wayBits    way to write
//   fillTag          in   tagBits    tag to store
//   clearing         out  1          CLEAR sweep in progress
//
// BEHAVIOUR
//   - Reset (sampled at rising edge) values: reqReady=0, rspValid=0, rspHit=0, rspWay=0,
//     rspHitVector=0, rspMultiHit=0, clearing=1. Pipeline flushed; FSM -> CLEAR, sweep counter=0.
//   - FSM CLEAR: clear all valid bits of set[counter] each cycle; counter += 1.
//     After set 2**indexBits-1: -> RUN. CLEAR takes exactly 2**indexBits cycles.
//     In CLEAR: reqReady=0, clearing=1, fill port ignored, tags need not be cleared.
//   - FSM RUN: reqReady=1, clearing=0. RUN returns to CLEAR only via reset.
//   - Reset mid-operation (any state): in-flight lookups dropped, no rspValid for them,
//     sweep restarts at set 0.
//   - Handshake: lookup accepted in cycle C when reqValid && reqReady.
//     Responses have no backpressure. One lookup per cycle, fully pipelined.
//   - Stage 1, edge ending C: capture reqTag plus {valid,tag} of every way of set reqIndex.
//   - Stage 2, edge ending C+1: register compare results.
//     rspValid=1 during C+2 only. Latency is fixed at 2 cycles.
//   - While rspValid=0, rspHit/rspWay/rspHitVector/rspMultiHit hold their last values
//     (0 after reset). Consumers qualify them with rspValid.
//   - Compare: hitVector[w] = valid[w] && (tag[w] == reqTag), full tagBits equality.
//     rspHit = |hitVector. rspWay = priority-encode lowest set bit.
//     rspMultiHit = popcount(hitVector) > 1.
//   - Fill: takes effect at the edge ending the cycle fillValid=1 (RUN only).
//     Invalidate leaves the stored tag unchanged.
//   - Fill/lookup ordering: a lookup accepted in the same cycle as a fill to its set sees
//     pre-fill contents. A lookup accepted one or more cycles later sees post-fill contents.
//     No bypass.
//   - Storage is flops (2**indexBits * ways * (tagBits+1) bits). No X on outputs after reset.
//
// TESTING
//   1. Reset 1 cycle, then idle: clearing=1 and reqReady=0 for exactly 64 cycles
//      (indexBits=6), then reqReady=1; all outputs 0 throughout.
//   2. Fill idx=5 way=2 tag=0xABC. Next cycle look up idx=5 tag=0xABC -> two cycles later
//      rspValid=1, rspHit=1, rspWay=2, rspHitVector=4'b0100.
//   3. Same-cycle fill idx=9 way=0 tag=0x123 and lookup idx=9 tag=0x123 -> miss.
//      Repeat the lookup next cycle -> hit, way 0.
//   4. Fill tag 0x7FF into idx=3 ways 1 and 3; look up 0x7FF -> rspHitVector=4'b1010,
//      rspWay=1, rspMultiHit=1. Invalidate way 1, look up again -> way 3, rspMultiHit=0.
//   5. Back-to-back lookups on 4 consecutive cycles (hit, miss, hit, miss) -> 4 consecutive
//      rspValid pulses, results in order. Lookup with tag differing only in MSB -> miss.
//   6. Reset asserted one cycle after a lookup is accepted -> no rspValid for it; 64-cycle
//      CLEAR repeats; an earlier filled entry now misses.

Source files
------------

// File: rtl/tag_lookup_unit_if.sv
// Lookup request/response, fill port and sweep status of the L2 tag store.
// The miss handler and address decoder use master; the tag store uses slave.
interface tag_lookup_unit_if #(
  parameter int tagBits   = 12,
  parameter int indexBits = 6,
  parameter int ways      = 4
);
  localparam int wayBits = $clog2(ways);

  logic                 reqValid;
  logic                 reqReady;
  logic [indexBits-1:0] reqIndex;
  logic [tagBits-1:0]   reqTag;
  logic                 rspValid;
  logic                 rspHit;
  logic [wayBits-1:0]   rspWay;
  logic [ways-1:0]      rspHitVector;
  logic                 rspMultiHit;
  logic                 fillValid;
  logic                 fillInvalidate;
  logic [indexBits-1:0] fillIndex;
  logic [wayBits-1:0]   fillWay;
  logic [tagBits-1:0]   fillTag;
  logic                 clearing;

  modport master (
    output reqValid, reqIndex, reqTag,
    output fillValid, fillInvalidate, fillIndex, fillWay, fillTag,
    input  reqReady, rspValid, rspHit, rspWay, rspHitVector, rspMultiHit, clearing
  );

  modport slave (
    input  reqValid, reqIndex, reqTag,
    input  fillValid, fillInvalidate, fillIndex, fillWay, fillTag,
    output reqReady, rspValid, rspHit, rspWay, rspHitVector, rspMultiHit, clearing
  );
endinterface

// File: rtl/tag_lookup_unit.sv
// N-way set-associative tag store with a two-stage parallel tag comparator.
// Valid bits are swept clear after reset; tags are left as-is.
module tag_lookup_unit #(
  parameter int tagBits   = 12,
  parameter int indexBits = 6,
  parameter int ways      = 4
) (
  input  logic             clock,
  input  logic             reset,
  tag_lookup_unit_if.slave bus
);
  localparam int sets    = 2 ** indexBits;
  localparam int wayBits = $clog2(ways);

  localparam logic [0:0] stateClear = 1'b0;
  localparam logic [0:0] stateRun   = 1'b1;

  logic [0:0]           stateReg;
  logic [indexBits-1:0] sweepReg;

  logic [ways-1:0]      validMem [sets];
  logic [tagBits-1:0]   tagMem   [sets][ways];

  logic                 s1ValidReg;
  logic [tagBits-1:0]   s1TagReg;
  logic [ways-1:0]      s1WayValidReg;
  logic [tagBits-1:0]   s1WayTagReg [ways];

  logic [ways-1:0]      hitVector;
  logic [wayBits-1:0]   hitWay;
  logic                 multiHit;

  logic                 rspValidReg;
  logic                 rspHitReg;
  logic [wayBits-1:0]   rspWayReg;
  logic [ways-1:0]      rspHitVectorReg;
  logic                 rspMultiHitReg;

  logic                 running;
  logic                 accept;

  assign running = (stateReg == stateRun);
  assign accept  = bus.reqValid && running;

  always_ff @(posedge clock) begin
    if (reset) begin
      stateReg <= stateClear;
      sweepReg <= '0;
    end else if (stateReg == stateClear) begin
      sweepReg <= sweepReg + 1'b1;
      if (&sweepReg) stateReg <= stateRun;
    end
  end

  // The sweep alone initialises valid bits, so the array needs no reset fan-out.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (!running)
        validMem[sweepReg] <= '0;
      else if (bus.fillValid)
        validMem[bus.fillIndex][bus.fillWay] <= !bus.fillInvalidate;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && running && bus.fillValid && !bus.fillInvalidate)
      tagMem[bus.fillIndex][bus.fillWay] <= bus.fillTag;
  end

  // Stage 1 reads pre-edge storage, so a same-cycle fill is not visible.
  always_ff @(posedge clock) begin
    if (reset) s1ValidReg <= 1'b0;
    else       s1ValidReg <= accept;
    s1TagReg      <= bus.reqTag;
    s1WayValidReg <= validMem[bus.reqIndex];
  end

  generate
    for (genvar gi = 0; gi < ways; gi++) begin : gWay
      always_ff @(posedge clock) begin
        s1WayTagReg[gi] <= tagMem[bus.reqIndex][gi];
      end
      assign hitVector[gi] = s1WayValidReg[gi] && (s1WayTagReg[gi] == s1TagReg);
    end
  endgenerate

  always_comb begin
    hitWay = '0;
    for (int w = ways - 1; w >= 0; w--) begin
      if (hitVector[w]) hitWay = wayBits'(w);
    end
  end

  assign multiHit = |(hitVector & (hitVector - 1'b1));

  always_ff @(posedge clock) begin
    if (reset) begin
      rspValidReg     <= 1'b0;
      rspHitReg       <= 1'b0;
      rspWayReg       <= '0;
      rspHitVectorReg <= '0;
      rspMultiHitReg  <= 1'b0;
    end else begin
      rspValidReg <= s1ValidReg;
      if (s1ValidReg) begin
        rspHitReg       <= |hitVector;
        rspWayReg       <= hitWay;
        rspHitVectorReg <= hitVector;
        rspMultiHitReg  <= multiHit;
      end
    end
  end

  assign bus.reqReady     = running;
  assign bus.clearing     = !running;
  assign bus.rspValid     = rspValidReg;
  assign bus.rspHit       = rspHitReg;
  assign bus.rspWay       = rspWayReg;
  assign bus.rspHitVector = rspHitVectorReg;
  assign bus.rspMultiHit  = rspMultiHitReg;
endmodule

// File: tb/tb_tag_lookup_unit.sv
// Randomised and directed bench for tag_lookup_unit with a queue-based scoreboard
// fed from an array model of the tag store.
module tb_tag_lookup_unit;
  localparam int TB   = 12;
  localparam int IB   = 6;
  localparam int W    = 4;
  localparam int SETS = 64;

  typedef struct {
    logic       hit;
    logic [1:0] way;
    logic [3:0] vec;
    logic       multi;
    int         cyc;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  tag_lookup_unit_if #(.tagBits(TB), .indexBits(IB), .ways(W)) bus ();

  tag_lookup_unit #(.tagBits(TB), .indexBits(IB), .ways(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad = 0;
  int cycCount = 0;
  exp_t expQ[$];
  exp_t monEntry;

  bit          refValid [SETS][W];
  logic [11:0] refTag   [SETS][W];

  always @(posedge clock) cycCount++;

  // Monitor: every response pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (bus.rspValid === 1'b1) begin
      total++;
      if (expQ.size() == 0) begin
        bad++;
        $display("FAIL unexpected_rsp cyc=%0d got hit=%b way=%0d vec=%b required none",
                 cycCount, bus.rspHit, bus.rspWay, bus.rspHitVector);
      end else begin
        monEntry = expQ.pop_front();
        if (bus.rspHit !== monEntry.hit || bus.rspWay !== monEntry.way ||
            bus.rspHitVector !== monEntry.vec || bus.rspMultiHit !== monEntry.multi ||
            cycCount != monEntry.cyc) begin
          bad++;
          $display("FAIL lookup_rsp cyc=%0d got hit=%b way=%0d vec=%b multi=%b required cyc=%0d hit=%b way=%0d vec=%b multi=%b",
                   cycCount, bus.rspHit, bus.rspWay, bus.rspHitVector, bus.rspMultiHit,
                   monEntry.cyc, monEntry.hit, monEntry.way, monEntry.vec, monEntry.multi);
        end else begin
          $display("rsp cyc=%0d hit=%b way=%0d vec=%b multi=%b ok",
                   cycCount, bus.rspHit, bus.rspWay, bus.rspHitVector, bus.rspMultiHit);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL timeout cyc=%0d", cycCount);
    $fatal(1, "timeout");
  end

  // One bench cycle: present inputs, predict the lookup from pre-fill contents,
  // then apply the fill to the model as the edge would.
  task automatic drive(input bit lk, input int idx, input logic [11:0] tg,
                       input bit fl, input bit inv, input int fidx, input int fway,
                       input logic [11:0] ftg);
    exp_t e;
    logic [5:0] i6;
    logic [5:0] f6;
    logic [1:0] w2;
    i6 = idx[5:0];
    f6 = fidx[5:0];
    w2 = fway[1:0];
    bus.reqValid       = lk;
    bus.reqIndex       = i6;
    bus.reqTag         = tg;
    bus.fillValid      = fl;
    bus.fillInvalidate = inv;
    bus.fillIndex      = f6;
    bus.fillWay        = w2;
    bus.fillTag        = ftg;
    if (lk) begin
      e.vec = '0;
      for (int w = 0; w < W; w++)
        e.vec[w] = refValid[i6][w] && (refTag[i6][w] == tg);
      e.hit = (e.vec != 0);
      e.way = '0;
      for (int w = 0; w < W; w++) begin
        if (e.vec[w]) begin
          e.way = 2'(w);
          break;
        end
      end
      e.multi = ($countones(e.vec) > 1);
      e.cyc   = cycCount + 2;
      expQ.push_back(e);
      $display("req cyc=%0d idx=%0d tag=%h exp hit=%b way=%0d vec=%b",
               cycCount, i6, tg, e.hit, e.way, e.vec);
    end
    if (fl) begin
      refValid[f6][w2] = !inv;
      if (!inv) refTag[f6][w2] = ftg;
    end
    @(posedge clock);
    #1;
    bus.reqValid  = 1'b0;
    bus.fillValid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(0, 0, 12'h0, 0, 0, 0, 0, 12'h0);
  endtask

  // Called just after a rising edge; reset is sampled on the next one.
  task automatic doReset();
    int n;
    reset = 1'b1;
    expQ.delete();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < W; w++) refValid[s][w] = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    n = 0;
    @(negedge clock);
    while (bus.clearing === 1'b1 && n < 200) begin
      total++;
      if (bus.reqReady !== 1'b0 || bus.rspValid !== 1'b0 || bus.rspHit !== 1'b0 ||
          bus.rspWay !== 2'd0 || bus.rspHitVector !== 4'd0 || bus.rspMultiHit !== 1'b0) begin
        bad++;
        $display("FAIL clear_outputs n=%0d got ready=%b valid=%b hit=%b way=%0d vec=%b multi=%b required all 0",
                 n, bus.reqReady, bus.rspValid, bus.rspHit, bus.rspWay, bus.rspHitVector, bus.rspMultiHit);
      end
      n++;
      @(negedge clock);
    end
    total++;
    if (n != 64 || bus.reqReady !== 1'b1) begin
      bad++;
      $display("FAIL clear_length got cycles=%0d ready=%b required cycles=64 ready=1", n, bus.reqReady);
    end else begin
      $display("clear cycles=%0d ready=%b ok", n, bus.reqReady);
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [11:0] pool [4];
    int ridx;
    bus.reqValid = 0; bus.reqIndex = '0; bus.reqTag = '0;
    bus.fillValid = 0; bus.fillInvalidate = 0; bus.fillIndex = '0;
    bus.fillWay = '0; bus.fillTag = '0;
    pool[0] = 12'h0AA; pool[1] = 12'h0AB; pool[2] = 12'h8AA; pool[3] = 12'h155;
    #1;

    // 1: reset and clear window
    doReset();

    // 2: fill then lookup next cycle
    drive(0, 0, 12'h0, 1, 0, 5, 2, 12'hABC);
    drive(1, 5, 12'hABC, 0, 0, 0, 0, 12'h0);
    idle(3);

    // 3: same-cycle fill/lookup sees old contents, next cycle sees new
    drive(1, 9, 12'h123, 1, 0, 9, 0, 12'h123);
    drive(1, 9, 12'h123, 0, 0, 0, 0, 12'h0);
    idle(3);

    // 4: multi-hit, then invalidate the lower way
    drive(0, 0, 12'h0, 1, 0, 3, 1, 12'h7FF);
    drive(0, 0, 12'h0, 1, 0, 3, 3, 12'h7FF);
    drive(1, 3, 12'h7FF, 0, 0, 0, 0, 12'h0);
    drive(0, 0, 12'h0, 1, 1, 3, 1, 12'h0);
    drive(1, 3, 12'h7FF, 0, 0, 0, 0, 12'h0);
    idle(3);

    // 5: back-to-back hit/miss/hit/miss and an MSB-only tag difference
    drive(0, 0, 12'h0, 1, 0, 10, 0, 12'h111);
    drive(0, 0, 12'h0, 1, 0, 11, 2, 12'h222);
    drive(1, 10, 12'h111, 0, 0, 0, 0, 12'h0);
    drive(1, 10, 12'h112, 0, 0, 0, 0, 12'h0);
    drive(1, 11, 12'h222, 0, 0, 0, 0, 12'h0);
    drive(1, 12, 12'h333, 0, 0, 0, 0, 12'h0);
    drive(1, 10, 12'h911, 0, 0, 0, 0, 12'h0);
    idle(3);

    // random mix over a few sets and a small tag pool to force hits and multi-hits
    for (int it = 0; it < 400; it++) begin
      ridx = $urandom_range(0, 7);
      drive($urandom_range(0, 1), ridx, pool[$urandom_range(0, 3)],
            $urandom_range(0, 1), ($urandom_range(0, 3) == 0),
            $urandom_range(0, 7), $urandom_range(0, 3), pool[$urandom_range(0, 3)]);
    end
    idle(3);

    // 6: reset one cycle after acceptance drops the lookup; earlier fill is gone
    drive(1, 5, 12'hABC, 0, 0, 0, 0, 12'h0);
    doReset();
    drive(1, 5, 12'hABC, 0, 0, 0, 0, 12'h0);
    idle(4);

    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("FAIL drain got outstanding=%0d required 0", expQ.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
